// File: rtl/fft_pkg.sv
// Shared types and default sizing for the FFT frame sequencer.
package fft_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_COMPUTE = 3'd3,
    S_UNLOAD  = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam int N_IN_DEF    = 64;
  localparam int N_OUT_DEF   = 32;
  localparam int TIMEOUT_DEF = 4096;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IN_IDX_W  = idx_w(N_IN_DEF);
  localparam int OUT_IDX_W = idx_w(N_OUT_DEF);

endpackage

// File: rtl/fft_sequencer_if.sv
// Handshake bundle between the sequencer (slave side) and its FFT/SPI/MCU environment.
interface fft_sequencer_if
  import fft_pkg::*;
#(
  parameter int IN_W  = IN_IDX_W,
  parameter int OUT_W = OUT_IDX_W
);
  logic             frame_ready;
  logic             fft_done;
  logic             result_ack;
  logic             fft_load;
  logic [IN_W-1:0]  fft_in_idx;
  logic             fft_start;
  logic             out_we;
  logic [OUT_W-1:0] out_idx;
  logic             result_ready;
  logic             busy;
  logic             timeout_err;
  logic             overrun_err;

  modport slave (
    input  frame_ready, fft_done, result_ack,
    output fft_load, fft_in_idx, fft_start, out_we, out_idx,
           result_ready, busy, timeout_err, overrun_err
  );

  modport master (
    output frame_ready, fft_done, result_ack,
    input  fft_load, fft_in_idx, fft_start, out_we, out_idx,
           result_ready, busy, timeout_err, overrun_err
  );
endinterface

// File: rtl/fft_sequencer_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);
  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_sync_d;
endmodule

// File: rtl/fft_sequencer.sv
// Frame sequencer: loads samples into the FFT, starts it, unloads results and
// holds them for the MCU, with compute timeout and frame-overrun flags.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_OUT   = N_OUT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  fft_sequencer_if.slave bus
);
  localparam int IN_W  = idx_w(N_IN);
  localparam int OUT_W = idx_w(N_OUT);
  localparam int TO_W  = idx_w(TIMEOUT);
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(N_IN - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(N_OUT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [IN_W-1:0]  r_load_cnt;
  logic [OUT_W-1:0] r_unload_cnt;
  logic [TO_W-1:0]  r_comp_cnt;
  logic             r_timeout_err;
  logic             r_overrun_err;
  logic             w_frame_evt;
  logic             w_set_timeout;
  logic             w_drop;

  sync_edge u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.frame_ready),
    .o_rise  (w_frame_evt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_set_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_frame_evt) w_next = S_LOAD;
        else             w_next = S_IDLE;
      end
      S_LOAD: begin
        if (r_load_cnt == IN_LAST) w_next = S_START;
        else                       w_next = S_LOAD;
      end
      S_START: w_next = S_COMPUTE;
      S_COMPUTE: begin
        // fft_done wins over a timeout landing in the same cycle.
        if (bus.fft_done) begin
          w_next = S_UNLOAD;
        end else if (r_comp_cnt == TO_LAST) begin
          w_next        = S_IDLE;
          w_set_timeout = 1'b1;
        end else begin
          w_next = S_COMPUTE;
        end
      end
      S_UNLOAD: begin
        if (bus.fft_done && (r_unload_cnt == OUT_LAST)) w_next = S_HOLD;
        else                                            w_next = S_UNLOAD;
      end
      S_HOLD: begin
        if (bus.result_ack) w_next = w_frame_evt ? S_LOAD : S_IDLE;
        else                w_next = S_HOLD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A frame event is consumed only from IDLE or by an acked HOLD.
  assign w_drop = w_frame_evt && (r_state != S_IDLE) &&
                  !((r_state == S_HOLD) && bus.result_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_cnt   <= '0;
      r_comp_cnt   <= '0;
      r_unload_cnt <= '0;
    end else begin
      if (r_state == S_LOAD)
        r_load_cnt <= (r_load_cnt == IN_LAST) ? '0 : r_load_cnt + IN_W'(1);
      else
        r_load_cnt <= '0;

      if (r_state == S_COMPUTE) r_comp_cnt <= r_comp_cnt + TO_W'(1);
      else                      r_comp_cnt <= '0;

      if (r_state != S_UNLOAD)
        r_unload_cnt <= '0;
      else if (bus.fft_done)
        r_unload_cnt <= (r_unload_cnt == OUT_LAST) ? '0 : r_unload_cnt + OUT_W'(1);
      else
        r_unload_cnt <= r_unload_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_timeout_err <= r_timeout_err | w_set_timeout;
      r_overrun_err <= r_overrun_err | w_drop;
    end
  end

  assign bus.fft_load     = (r_state == S_LOAD);
  assign bus.fft_in_idx   = (r_state == S_LOAD) ? r_load_cnt : '0;
  assign bus.fft_start    = (r_state == S_START);
  assign bus.out_we       = (r_state == S_UNLOAD) && bus.fft_done;
  assign bus.out_idx      = (r_state == S_UNLOAD) ? r_unload_cnt : '0;
  assign bus.result_ready = (r_state == S_HOLD);
  assign bus.busy         = (r_state == S_LOAD) || (r_state == S_START) ||
                            (r_state == S_COMPUTE) || (r_state == S_UNLOAD);
  assign bus.timeout_err  = r_timeout_err;
  assign bus.overrun_err  = r_overrun_err;
endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 Parameter N_IN, default 64: samples loaded into the FFT per frame.
REQ-002 Parameter N_OUT, default 32: 32-bit result words unloaded per frame.
REQ-003 Parameter TIMEOUT, default 4096: maximum clk cycles spent in COMPUTE.
REQ-004 clk  input  1  single system clock; all state SHALL be updated on rising edges.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 frame_ready  input  1  SPI frame-complete level, asynchronous to clk.
REQ-007 fft_done  input  1  FFT result-valid level.
REQ-008 result_ack  input  1  MCU readout-complete pulse, synchronous to clk.
REQ-009 fft_load  output  1  high while an input sample is being presented.
REQ-010 fft_in_idx  output  $clog2(N_IN)  index of the sample being loaded.
REQ-011 fft_start  output  1  one-cycle pulse that starts the transform.
REQ-012 out_we  output  1  write strobe for one result word.
REQ-013 out_idx  output  $clog2(N_OUT)  index of the result word being written.
REQ-014 result_ready  output  1  level; the full result buffer is valid for the MCU.
REQ-015 busy  output  1  high in states LOAD, START, COMPUTE and UNLOAD.
REQ-016 timeout_err  output  1  sticky; COMPUTE exceeded TIMEOUT.
REQ-017 overrun_err  output  1  sticky; a frame event was dropped.

Function
REQ-018 frame_ready SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; one rising edge produces one frame event.
REQ-019 FSM states SHALL be IDLE, LOAD, START, COMPUTE, UNLOAD and HOLD.
REQ-020 IDLE SHALL go to LOAD on a frame event; fft_load SHALL first be high after the 3rd rising clk edge following the frame_ready rise.
REQ-021 LOAD SHALL:
- assert fft_load for exactly N_IN consecutive cycles;
- step fft_in_idx 0..N_IN-1, one value per cycle;
- go to START after index N_IN-1.
REQ-022 START SHALL assert fft_start for exactly one cycle, then go to COMPUTE.
REQ-023 COMPUTE SHALL:
- clear its cycle counter on entry;
- go to UNLOAD when fft_done=1;
- go to IDLE and set timeout_err when the counter reaches TIMEOUT-1 without fft_done.
REQ-024 UNLOAD SHALL:
- assert out_we only in cycles where fft_done=1;
- advance out_idx 0..N_OUT-1 only on those cycles;
- hold out_idx and keep out_we=0 while fft_done=0;
- go to HOLD after word N_OUT-1 is written.
REQ-025 HOLD SHALL hold result_ready=1.
REQ-026 HOLD with result_ack=1 SHALL go to IDLE.
REQ-027 HOLD with result_ack=1 and a frame event in the same cycle SHALL go directly to LOAD, without setting overrun_err.
REQ-028 A frame event in any state other than IDLE, except the case in REQ-027, SHALL be dropped and SHALL set overrun_err.
REQ-029 result_ack outside HOLD SHALL be ignored.
REQ-030 fft_done outside COMPUTE and UNLOAD SHALL be ignored.
REQ-031 fft_load, fft_start, out_we and result_ready SHALL be mutually exclusive in every cycle.
REQ-032 fft_in_idx SHALL read 0 outside LOAD, and out_idx SHALL read 0 outside UNLOAD.
REQ-033 Error flags SHALL never alter the FSM sequence, and SHALL be cleared only by reset.

Reset
REQ-034 While reset=1, the FSM SHALL be IDLE, all counters 0, synchronizer flops 0, and every output 0.
REQ-035 Reset asserted mid-frame, in any state, SHALL abort immediately with no further fft_load, fft_start or out_we.
REQ-036 If frame_ready is already high at reset release, the block SHALL produce one frame event.

Structure
REQ-037 Package fft_pkg SHALL hold the state enum type, the default N_IN, N_OUT and TIMEOUT, and the derived index widths.
REQ-038 Sub-module sync_edge SHALL contain the 2-flop synchronizer and the rising-edge detector, and SHALL be reset by reset.
REQ-039 The FSM and the three counters (load, compute and unload) SHALL reside in fft_sequencer.

Verification
REQ-040 Nominal frame: frame_ready rises, then fft_done rises 100 cycles after fft_start -> exactly 64 fft_load cycles (idx 0..63), 1 fft_start, 32 out_we (idx 0..31), then result_ready=1 until result_ack.
REQ-041 fft_done deasserted for 5 cycles during UNLOAD at out_idx=10 -> out_idx holds at 10 with out_we=0, resumes, and still produces exactly 32 writes.
REQ-042 fft_done never asserted, with TIMEOUT=16 -> return to IDLE 16 cycles after fft_start with timeout_err=1; a following frame completes normally.
REQ-043 Second frame_ready edge during LOAD -> overrun_err=1 and the current frame completes unchanged; ack coinciding with a frame event in HOLD -> LOAD entered and overrun_err stays 0.
REQ-044 Reset pulsed at fft_in_idx=30 -> all outputs 0 on the same cycle, state IDLE; frame_ready held high across release -> exactly one new frame.
